// File: rtl/exc_pkg.sv
// Shared definitions for the exception vector unit: cause encodings,
// FSM state type/constants and the default vector-table base address.
package exc_pkg;

  // Cause encodings as seen on exc_cause and used to index the vector table
  localparam logic [1:0] CAUSE_OPCODE = 2'd0;
  localparam logic [1:0] CAUSE_OVF    = 2'd1;
  localparam logic [1:0] CAUSE_DIV0   = 2'd2;

  // FSM state type and its constants
  typedef logic [1:0] exc_state_t;
  localparam exc_state_t ST_IDLE  = 2'd0;
  localparam exc_state_t ST_FETCH = 2'd1;
  localparam exc_state_t ST_DONE  = 2'd2;

  // Byte address of the cause-0 vector entry in the memory map
  localparam logic [31:0] EXC_VEC_BASE = 32'd253;

endpackage

// File: rtl/exc_prio_enc.sv
// Combinational 3-to-2 priority encoder for exception pulses.
// Priority: opcode > overflow > divzero.
module exc_prio_enc
  import exc_pkg::*;
(
  input  logic       i_exc_opcode,
  input  logic       i_exc_overflow,
  input  logic       i_exc_divzero,
  output logic [1:0] o_cause,
  output logic       o_any
);

  // Pick the highest-priority pending exception
  always_comb begin
    o_cause = CAUSE_OPCODE;
    o_any   = 1'b0;
    if (i_exc_opcode) begin
      o_cause = CAUSE_OPCODE;
      o_any   = 1'b1;
    end else if (i_exc_overflow) begin
      o_cause = CAUSE_OVF;
      o_any   = 1'b1;
    end else if (i_exc_divzero) begin
      o_cause = CAUSE_DIV0;
      o_any   = 1'b1;
    end else begin
      o_cause = CAUSE_OPCODE;
      o_any   = 1'b0;
    end
  end

endmodule

// File: rtl/exc_vector_unit.sv
// Exception entry stage: latches cause and EPC, fetches the 8-bit handler
// address from the vector table over req/ack and strobes it to the PC mux.
// Optional fetch timeout with fallback vector: define EXC_TIMEOUT_EN.
module exc_vector_unit
  import exc_pkg::*;
#(
  parameter logic [31:0] VEC_BASE    = EXC_VEC_BASE,
  parameter logic [31:0] EPC_OFFSET  = 32'd4,
  parameter int          TIMEOUT     = 15,
  parameter logic [31:0] DEFAULT_VEC = 32'd0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        exc_opcode,
  input  logic        exc_overflow,
  input  logic        exc_divzero,
  input  logic [31:0] pc_in,
  input  logic        mem_ack,
  input  logic [7:0]  mem_rdata,
  output logic        mem_req,
  output logic [31:0] mem_addr,
  output logic [31:0] epc,
  output logic [1:0]  exc_cause,
  output logic [31:0] vec_addr,
  output logic        vec_valid,
  output logic        busy
);

  logic [1:0]  w_cause;
  logic        w_any;

  exc_state_t  r_state;
  logic        r_mem_req;
  logic [31:0] r_mem_addr;
  logic [31:0] r_epc;
  logic [1:0]  r_cause;
  logic [31:0] r_vec_addr;
  logic        r_vec_valid;
  logic        r_busy;

`ifdef EXC_TIMEOUT_EN
  // Wide enough for TIMEOUT, never narrower than 4 bits
  localparam int WAIT_W = ($clog2(TIMEOUT + 1) < 4) ? 4 : $clog2(TIMEOUT + 1);
  logic [WAIT_W-1:0] r_wait;
`else
  // Timeout configuration is only consumed when the feature is built in
  logic w_unused_cfg;
  assign w_unused_cfg = ^{DEFAULT_VEC, TIMEOUT};
`endif

  exc_prio_enc u_prio (
    .i_exc_opcode   (exc_opcode),
    .i_exc_overflow (exc_overflow),
    .i_exc_divzero  (exc_divzero),
    .o_cause        (w_cause),
    .o_any          (w_any)
  );

  // Exception FSM: accept in IDLE only, fetch vector, strobe for one cycle
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= ST_IDLE;
      r_mem_req   <= 1'b0;
      r_mem_addr  <= 32'd0;
      r_epc       <= 32'd0;
      r_cause     <= 2'd0;
      r_vec_addr  <= 32'd0;
      r_vec_valid <= 1'b0;
      r_busy      <= 1'b0;
`ifdef EXC_TIMEOUT_EN
      r_wait      <= '0;
`endif
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_any) begin
            r_state    <= ST_FETCH;
            r_cause    <= w_cause;
            r_epc      <= pc_in - EPC_OFFSET;
            r_mem_addr <= VEC_BASE + {30'd0, w_cause};
            r_mem_req  <= 1'b1;
            r_busy     <= 1'b1;
`ifdef EXC_TIMEOUT_EN
            r_wait     <= '0;
`endif
          end
        end
        ST_FETCH: begin
          if (mem_ack) begin
            r_vec_addr  <= {24'd0, mem_rdata};
            r_mem_req   <= 1'b0;
            r_vec_valid <= 1'b1;
            r_state     <= ST_DONE;
          end
`ifdef EXC_TIMEOUT_EN
          // Last permitted ack-less cycle: fall back to the default handler
          else if (r_wait == WAIT_W'(TIMEOUT - 1)) begin
            r_vec_addr  <= DEFAULT_VEC;
            r_mem_req   <= 1'b0;
            r_vec_valid <= 1'b1;
            r_state     <= ST_DONE;
          end else begin
            r_wait <= r_wait + 1'b1;
          end
`endif
        end
        ST_DONE: begin
          r_vec_valid <= 1'b0;
          r_busy      <= 1'b0;
          r_state     <= ST_IDLE;
        end
        default: begin
          r_state     <= ST_IDLE;
          r_mem_req   <= 1'b0;
          r_vec_valid <= 1'b0;
          r_busy      <= 1'b0;
        end
      endcase
    end
  end

  assign mem_req   = r_mem_req;
  assign mem_addr  = r_mem_addr;
  assign epc       = r_epc;
  assign exc_cause = r_cause;
  assign vec_addr  = r_vec_addr;
  assign vec_valid = r_vec_valid;
  assign busy      = r_busy;

endmodule

// File: doc/exc_vector_unit.md
Name: exc_vector_unit

Overview:
- Exception entry stage directly upstream of the PC source mux: produces the handler address that feeds the mux's select-3 input.
- Detects exception pulses, saves EPC, and fetches the 8-bit handler address from the vector table over a req/ack memory handshake.
- Presents the zero-extended address with a one-cycle valid strobe so control selects mux input 3 and writes PC.

Parameters:
- VEC_BASE, 32'd253, byte address of vector entry for cause 0; causes 1 and 2 sit at +1 and +2.
- EPC_OFFSET, 32'd4, subtracted from pc_in when EPC is captured.
- TIMEOUT, 15, max FETCH cycles without ack (used only with the optional feature).
- DEFAULT_VEC, 32'd0, fallback handler address on timeout (optional feature).

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  synchronous, active-high.
- exc_opcode  in  1  invalid-opcode exception pulse.
- exc_overflow  in  1  ALU overflow exception pulse.
- exc_divzero  in  1  divide-by-zero exception pulse.
- pc_in  in  32  current PC register value.
- mem_ack  in  1  memory read complete; mem_rdata valid this cycle.
- mem_rdata  in  8  vector table byte.
- mem_req  out  1  read request, held until ack.
- mem_addr  out  32  vector table byte address.
- epc  out  32  saved exception PC.
- exc_cause  out  2  latched cause: 0 opcode, 1 overflow, 2 divzero.
- vec_addr  out  32  handler address to PC mux input 3.
- vec_valid  out  1  one-cycle strobe: vec_addr ready, control writes PC.
- busy  out  1  high in any state other than IDLE.

Behaviour:
- Reset, or reset asserted mid-operation: state IDLE; mem_req, vec_valid, busy = 0; epc, vec_addr, mem_addr = 0; exc_cause = 0. Any pending fetch is abandoned; a late mem_ack is ignored.
- FSM states: IDLE, FETCH, DONE.
- IDLE to FETCH on a clock edge where any exc_* is high.
  - Priority when simultaneous: opcode > overflow > divzero.
  - On that edge: exc_cause latched; epc = pc_in - EPC_OFFSET, mod 2^32 (pc_in = 0 gives 0xFFFFFFFC); mem_addr = VEC_BASE + cause.
- FETCH: mem_req = 1, mem_addr stable.
  - On an edge with mem_ack = 1: vec_addr = {24'b0, mem_rdata}; go to DONE.
- DONE: vec_valid = 1 for exactly one cycle, mem_req = 0; then go to IDLE.
- Latency: exception sampled at edge 0 with ack in the first FETCH cycle gives vec_valid high during cycle 2. Each extra ack wait cycle adds one.
- Exceptions arriving while busy = 1 are dropped: no queueing, and epc and cause are not disturbed.
- An exception on the edge leaving DONE is also dropped. It is accepted only in IDLE.
- epc, exc_cause and vec_addr hold their values until the next accepted exception.
- mem_ack outside FETCH is ignored.

Optional Feature:
- Macro: EXC_TIMEOUT_EN.
- Defined: a 4-bit-or-wider wait counter clears on entry to FETCH and increments each FETCH cycle without ack. After TIMEOUT cycles without ack: vec_addr = DEFAULT_VEC, go to DONE, mem_req drops.
- Not defined: FETCH waits indefinitely for mem_ack; no counter is instantiated.

Decomposition:
- Shared package exc_pkg: cause encoding constants (CAUSE_OPCODE = 0, CAUSE_OVF = 1, CAUSE_DIV0 = 2), FSM state typedef, and the VEC_BASE default constant shared with the memory map.
- One sub-module: exc_prio_enc, a combinational 3-to-2 priority encoder producing cause and an any-exception flag.

Test Plan:
- Overflow pulse with pc_in = 0x0000_0040; ack 1 cycle later with rdata = 0x7C -> epc = 0x3C, mem_addr = 254, exc_cause = 1, vec_addr = 0x7C, single vec_valid pulse.
- exc_opcode and exc_divzero high on the same edge -> exc_cause = 0, mem_addr = 253.
- Overflow while in FETCH (busy = 1) -> ignored; epc and cause unchanged; exactly one vec_valid.
- pc_in = 0 on accepted exception -> epc = 0xFFFFFFFC.
- Reset asserted in FETCH with mem_req = 1, ack the next cycle -> all outputs 0, state IDLE, no vec_valid.
- With EXC_TIMEOUT_EN, TIMEOUT = 15, no ack -> vec_addr = DEFAULT_VEC and vec_valid asserted after 15 FETCH cycles; mem_req low afterwards.
